// File: rtl/enable_signal_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enable_signal_encoder_pkg
// Purpose  : Shared definitions for the enable-pattern encoder and decoder:
//            code/pattern widths, the fixed 16-entry code-to-pattern table
//            and the encoder FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package enable_signal_encoder_pkg;

    localparam int c_code_w    = 4;
    localparam int c_pattern_w = 16;
    localparam int c_entries   = 1 << c_code_w;

    // Entry [k] is the enable pattern driven for code k.
    localparam logic [c_pattern_w-1:0] c_pattern_table [c_entries] = '{
        16'h8000, 16'hC000, 16'h6000, 16'h3000,
        16'h2800, 16'h0C00, 16'h0600, 16'h6300,
        16'h0880, 16'h0240, 16'h00A0, 16'h0990,
        16'h00D8, 16'h600C, 16'h0006, 16'h002D
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } enc_state_t;

endpackage : enable_signal_encoder_pkg
`default_nettype wire

// File: rtl/enable_pattern_rom.sv
`default_nettype none
// ============================================================================
// Module   : enable_pattern_rom
// Purpose  : Combinational lookup of one entry of the shared pattern table.
// Ports    : index   - in,  4-bit table index
//            pattern - out, 16-bit pattern stored at that index
// Revision : 1.0 - initial release
// ============================================================================
module enable_pattern_rom
    import enable_signal_encoder_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] pattern
);

    assign pattern = c_pattern_table[index];

endmodule : enable_pattern_rom
`default_nettype wire

// File: rtl/enable_signal_encoder.sv
`default_nettype none
// ============================================================================
// Module   : enable_signal_encoder
// Purpose  : Reverse-maps a 16-bit enable pattern to its 4-bit code by
//            walking the shared pattern table one entry per cycle.
//            Valid/ready handshakes on both sides; saturating miss counter.
// Ports    : clk        - in,  clock (rising edge)
//            rst        - in,  asynchronous active-high reset
//            in_valid   - in,  pattern available upstream
//            in_pattern - in,  16-bit pattern to encode
//            in_ready   - out, block is idle and will accept a pattern
//            out_valid  - out, out_code/out_hit are valid
//            out_ready  - in,  downstream accepts the result
//            out_code   - out, matching code (0 on miss)
//            out_hit    - out, 1 = exact match found
//            miss_count - out, saturating count of missed lookups
// Revision : 1.0 - initial release
// ============================================================================
module enable_signal_encoder
    import enable_signal_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_pattern,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_code,
    output logic        out_hit,
    output logic [7:0]  miss_count
);

    localparam logic [3:0] c_last_index = 4'hF;
    localparam logic [7:0] c_count_max  = 8'hFF;

    enc_state_t  r_state;
    logic [3:0]  r_index;
    logic [15:0] r_pattern;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [3:0]  r_out_code;
    logic        r_out_hit;
    logic [7:0]  r_miss_count;

    logic [15:0] w_rom_pattern;

    enable_pattern_rom u_rom (
        .index   (r_index),
        .pattern (w_rom_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= 4'h0;
            r_pattern    <= 16'h0000;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_code   <= 4'h0;
            r_out_hit    <= 1'b0;
            r_miss_count <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_pattern  <= in_pattern;
                        r_index    <= 4'h0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    // A zero pattern can never match, so finish it as a miss
                    // without walking the table.
                    if ((r_pattern != 16'h0000) && (w_rom_pattern == r_pattern)) begin
                        r_out_code  <= r_index;
                        r_out_hit   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if ((r_pattern == 16'h0000) || (r_index == c_last_index)) begin
                        r_out_code  <= 4'h0;
                        r_out_hit   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                        if (r_miss_count != c_count_max) begin
                            r_miss_count <= r_miss_count + 8'd1;
                        end
                    end else begin
                        r_index <= r_index + 4'd1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_index     <= 4'h0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_index     <= 4'h0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_code   = r_out_code;
    assign out_hit    = r_out_hit;
    assign miss_count = r_miss_count;

endmodule : enable_signal_encoder
`default_nettype wire

// File: tb/tb_enable_signal_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_enable_signal_encoder
// Purpose  : Directed self-checking bench for enable_signal_encoder.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_enable_signal_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_pattern;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_code;
    logic        out_hit;
    logic [7:0]  miss_count;

    int checks;
    int errors;

    enable_signal_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pattern (in_pattern),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_hit    (out_hit),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present the pattern, and return after the accept
    // edge E0 (sampled #1 later). Input pattern is scrambled afterwards.
    task automatic accept(input logic [15:0] pat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_pattern = pat;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_pattern = 16'h5A5A;
    endtask

    // Count edges after E0 until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [15:0] pat, input int exp_lat,
                          input logic [3:0] exp_code, input logic exp_hit, input bit check);
        int lat;
        accept(pat);
        wait_result(lat);
        if (check) begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_code"}, 32'(out_code), 32'(exp_code));
            chk({tag, "_hit"}, 32'(out_hit), 32'(exp_hit));
        end
        release_result();
        if (check) chk({tag, "_back_to_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
    endtask

    initial begin
        int lat;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pattern = 16'h0000;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_code", 32'(out_code), 32'd0);
        chk("reset_out_hit", 32'(out_hit), 32'd0);
        chk("reset_miss_count", 32'(miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Hits at the first, last and a middle index.
        lookup("p8000", 16'h8000, 1, 4'h0, 1'b1, 1'b1);
        lookup("p002D", 16'h002D, 16, 4'hF, 1'b1, 1'b1);
        lookup("p00A0", 16'h00A0, 11, 4'hA, 1'b1, 1'b1);

        // Misses: unknown pattern walks the whole table, zero finishes at once.
        lookup("p1234", 16'h1234, 16, 4'h0, 1'b0, 1'b1);
        chk("miss_count_1", 32'(miss_count), 32'd1);
        lookup("p0000", 16'h0000, 1, 4'h0, 1'b0, 1'b1);
        chk("miss_count_2", 32'(miss_count), 32'd2);

        // Backpressure: result held while out_ready stays low.
        accept(16'h0006);
        wait_result(lat);
        chk("hold_latency", 32'(lat), 32'd15);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_state", {24'd0, out_valid, in_ready, out_hit, 1'b0, out_code}, {24'd0, 8'b1010_1110});
        end
        release_result();
        chk("hold_released", {30'd0, in_ready, out_valid}, 32'h2);

        // Reset in the middle of a search aborts it.
        accept(16'h0990);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {16'd0, out_valid, out_hit, 2'b00, out_code, miss_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_result", {30'd0, in_ready, out_valid}, 32'h2);
        lookup("p0990", 16'h0990, 12, 4'hB, 1'b1, 1'b1);
        chk("miss_count_after_abort", 32'(miss_count), 32'd0);

        // Saturation of the miss counter.
        for (int i = 0; i < 254; i++) lookup("sat", 16'h0000, 1, 4'h0, 1'b0, 1'b0);
        chk("miss_count_254", 32'(miss_count), 32'hFE);
        lookup("sat255", 16'h0000, 1, 4'h0, 1'b0, 1'b0);
        chk("miss_count_255", 32'(miss_count), 32'hFF);
        for (int i = 0; i < 45; i++) lookup("sat", 16'h0000, 1, 4'h0, 1'b0, 1'b0);
        chk("miss_count_300", 32'(miss_count), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_enable_signal_encoder
`default_nettype wire

// File: doc/enable_signal_encoder.md
ENABLE_SIGNAL_ENCODER -- requirements
Module: enable_signal_encoder

Interface
REQ-001 Parameters: none; the pattern table is fixed and lives in the shared package.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream has a 16-bit enable pattern to encode.
REQ-005 in_pattern  input  16  enable pattern to reverse-map to its 4-bit code.
REQ-006 in_ready  output  1  block can accept a pattern; high only in IDLE.
REQ-007 out_valid  output  1  result (out_code, out_hit) is valid.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_code  output  4  code whose table entry equals the pattern; 4'h0 on miss.
REQ-010 out_hit  output  1  1 = exact match found, 0 = pattern not in table.
REQ-011 miss_count  output  8  saturating count of completed lookups with out_hit=0.

Function
REQ-012 The table SHALL map code to pattern (hex): 0:8000 1:C000 2:6000 3:3000 4:2800 5:0C00 6:0600 7:6300 8:0880 9:0240 A:00A0 B:0990 C:00D8 D:600C E:0006 F:002D.
REQ-013 FSM states SHALL be IDLE, SEARCH, DONE.
REQ-014 IDLE: on in_valid&&in_ready, capture in_pattern, set index=0, go to SEARCH.
REQ-015 SEARCH: one table entry compared per cycle, exact 16-bit equality against the captured pattern.
REQ-016 Match at index k: next edge go to DONE with out_code=k, out_hit=1.
REQ-017 No match at index 15: next edge go to DONE with out_code=0, out_hit=0, miss_count incremented.
REQ-018 Captured pattern 16'h0000: next edge go to DONE as a miss (no table entry is zero).
REQ-019 Latency: with accept edge E0, out_valid rises after edge E(k+1) on a hit at index k, after E16 on a miss, after E1 for a zero pattern.
REQ-020 DONE: out_valid=1 with out_code/out_hit held stable until out_valid&&out_ready; then return to IDLE.
REQ-021 Fastest throughput SHALL be one lookup every k+3 cycles; in_ready stays low in SEARCH and DONE.
REQ-022 in_pattern changes while not in IDLE SHALL NOT affect the current lookup.
REQ-023 miss_count SHALL saturate at 8'hFF and never wrap.
REQ-024 Index counter SHALL never run past 15; no wrap to 0 inside a lookup.

Reset
REQ-025 On rst: state=IDLE, index=0, captured pattern=0, out_valid=0, out_code=0, out_hit=0, miss_count=0; in_ready=1 once rst deasserts.
REQ-026 Reset mid-SEARCH or mid-DONE SHALL abort the lookup with no result emitted and no miss_count change.

Structure
REQ-027 The shared package SHALL hold the 16x16 pattern table constant, state enum type, and code/pattern width constants; the existing decoder uses the same table.
REQ-028 One sub-module, enable_pattern_rom (4-bit index in, 16-bit pattern out, combinational), SHALL supply table entries.

Verification
REQ-029 Send 16'h8000 -> out_valid after E1, out_code=0, out_hit=1.
REQ-030 Send 16'h002D -> out_valid after E16, out_code=F, out_hit=1; then 16'h00A0 -> out_code=A after E11.
REQ-031 Send 16'h1234 -> out_valid after E16, out_hit=0, out_code=0, miss_count=1; send 16'h0000 -> miss after E1, miss_count=2.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_code, out_hit stable; in_ready=0 throughout.
REQ-033 Assert rst during SEARCH for 16'h0990 -> outputs zero immediately, no out_valid; next lookup 16'h0990 -> out_code=B.
REQ-034 Drive 300 misses -> miss_count saturates at 8'hFF.
